// File: rtl/video_pkg.sv
// Shared video-pipeline definitions: fetch FSM encoding, default address map
// constants, the timing bundle and a constant-evaluable clog2.
package video_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_T0   = 2'd1;
    localparam logic [1:0] ST_T1   = 2'd2;
    localparam logic [1:0] ST_T2   = 2'd3;

    localparam logic [11:0] DEF_CHAR_BASE     = 12'h000;
    localparam int          DEF_CHAR_LINE_ADD = 60;
    localparam logic [11:0] DEF_ATTR_BASE     = 12'h9C0;
    localparam int          DEF_ATTR_LINE_ADD = 40;
    localparam logic [7:0]  DEF_ATTR_VAL      = 8'h07;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hpix;
        logic vpix;
    } vtiming_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/text_shifter.sv
// Per-cell pixel serialiser: loads a font row and its attribute at the cell
// boundary, then shifts one pixel out per pix_stb, MSB first.
module text_shifter
    import video_pkg::*;
#(
    parameter int         CHAR_W   = 8,
    parameter logic [7:0] DEF_ATTR = DEF_ATTR_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_stb,
    input  logic              load,
    input  logic [CHAR_W-1:0] font,
    input  logic [7:0]        attr,
    input  logic              pix_en,
    output logic              o_pix,
    output logic [7:0]        o_attr
);

    logic [CHAR_W-1:0] shifter;
    logic [7:0]        cur_attr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifter  <= '0;
            cur_attr <= DEF_ATTR;
        end else if (pix_stb) begin
            if (load) begin
                shifter  <= font;
                cur_attr <= attr;
            end else begin
                shifter <= {shifter[CHAR_W-2:0], 1'b0};
            end
        end
    end

    // Blank outside the active area so the DAC sees paper during sync/porch.
    assign o_pix  = shifter[CHAR_W-1] & pix_en;
    assign o_attr = cur_attr;

endmodule

// File: rtl/text_fetch_gen.sv
// Text-mode fetch engine: row/column address counters, a 3-tick char/attr/font
// prefetch one cell ahead, and a pixel shifter with matched sync delay.
module text_fetch_gen
    import video_pkg::*;
#(
    parameter int          CHAR_W        = 8,
    parameter int          CHAR_H        = 8,
    parameter int          LINE_W        = 3,
    parameter int          CODE_W        = 8,
    parameter logic [11:0] CHAR_BASE     = DEF_CHAR_BASE,
    parameter int          CHAR_LINE_ADD = DEF_CHAR_LINE_ADD,
    parameter int          ATTR_EN       = 1,
    parameter logic [11:0] ATTR_BASE     = DEF_ATTR_BASE,
    parameter int          ATTR_LINE_ADD = DEF_ATTR_LINE_ADD,
    parameter logic [7:0]  DEF_ATTR      = DEF_ATTR_VAL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_stb,
    input  logic                     i_hsync,
    input  logic                     i_vsync,
    input  logic                     i_hpix,
    input  logic                     i_vpix,
    input  logic                     v_init,
    input  logic                     h_init,
    input  logic                     h_step,
    input  logic                     h_char,
    output logic                     char_r_rdena,
    output logic [11:0]              char_r_addr,
    input  logic [7:0]               char_r_data,
    output logic [CODE_W+LINE_W-1:0] font_r_addr,
    input  logic [7:0]               font_r_data,
    output logic                     o_pix,
    output logic [7:0]               o_attr,
    output logic                     o_hsync,
    output logic                     o_vsync,
    output logic                     o_hpix,
    output logic                     o_vpix
);

    if (clog2(CHAR_H) > LINE_W || CHAR_W < 3 || CHAR_W > 8 || CODE_W > 8) begin : g_cfg_err
        $error("text_fetch_gen: unsupported CHAR_W/CHAR_H/LINE_W/CODE_W combination");
    end

    logic [LINE_W-1:0] line;
    logic [11:0]       char_row, attr_row;
    logic [11:0]       char_col, attr_col;
    logic [1:0]        state;
    logic              armed;
    logic              start;
    logic              char_pend, attr_pend, font_pend;
    logic [CODE_W-1:0] code;
    logic [7:0]        font_stage, attr_stage;
    vtiming_t          tm_d;

    // Row counters: v_init rewinds the frame, h_step advances the font line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line     <= '0;
            char_row <= '0;
            attr_row <= '0;
        end else if (pix_stb) begin
            if (v_init) begin
                line     <= '0;
                char_row <= CHAR_BASE;
                attr_row <= ATTR_BASE;
            end else if (h_step) begin
                if (line == LINE_W'(CHAR_H - 1)) begin
                    line     <= '0;
                    char_row <= char_row + 12'(CHAR_LINE_ADD);
                    attr_row <= attr_row + 12'(ATTR_LINE_ADD);
                end else begin
                    line <= line + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_col <= '0;
            attr_col <= '0;
        end else if (pix_stb) begin
            if (h_init) begin
                char_col <= char_row;
                attr_col <= attr_row;
            end else if (h_char) begin
                char_col <= char_col + 12'd1;
                attr_col <= attr_col + 12'd1;
            end
        end
    end

    // After reset, h_char alone must not start fetching; wait for a line start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     armed <= 1'b0;
        else if (pix_stb && h_init)  armed <= 1'b1;
    end

    assign start = pix_stb && (h_init || (h_char && armed));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (start) begin
            state <= ST_T0;
        end else if (pix_stb) begin
            case (state)
                ST_T0:   state <= ST_T1;
                ST_T1:   state <= ST_T2;
                ST_T2:   state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data lands one clk after its address, so the pending flags run
    // every clk rather than on pix_stb; repeated captures during pix_stb
    // gaps see the same stable address and data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_pend <= 1'b0;
            attr_pend <= 1'b0;
            font_pend <= 1'b0;
        end else begin
            char_pend <= (state == ST_T0);
            attr_pend <= (ATTR_EN != 0) && (state == ST_T1);
            font_pend <= (state == ST_T2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code       <= '0;
            font_stage <= '0;
            attr_stage <= '0;
        end else begin
            if (char_pend) code <= char_r_data[CODE_W-1:0];
            if (font_pend) font_stage <= font_r_data;
            if (ATTR_EN == 0)   attr_stage <= DEF_ATTR;
            else if (attr_pend) attr_stage <= char_r_data;
        end
    end

    assign char_r_rdena = (state == ST_T0) || ((ATTR_EN != 0) && (state == ST_T1));
    assign char_r_addr  = (state == ST_T1) ? attr_col : char_col;
    assign font_r_addr  = {code, line};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          tm_d <= '0;
        else if (pix_stb) tm_d <= '{hsync: i_hsync, vsync: i_vsync, hpix: i_hpix, vpix: i_vpix};
    end

    assign o_hsync = tm_d.hsync;
    assign o_vsync = tm_d.vsync;
    assign o_hpix  = tm_d.hpix;
    assign o_vpix  = tm_d.vpix;

    text_shifter #(
        .CHAR_W   (CHAR_W),
        .DEF_ATTR (DEF_ATTR)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .pix_stb (pix_stb),
        .load    (h_char),
        .font    (font_stage[7 -: CHAR_W]),
        .attr    (attr_stage),
        .pix_en  (tm_d.hpix & tm_d.vpix),
        .o_pix   (o_pix),
        .o_attr  (o_attr)
    );

endmodule

// File: tb/tb_text_fetch_gen.sv
// Directed bench for text_fetch_gen: one instance with per-cell attributes,
// one with ATTR_EN=0, both fed by behavioural 1-clk-latency memories.
module tb_text_fetch_gen;

    logic clk = 1'b0;
    logic rst, pix_stb;
    logic i_hsync, i_vsync, i_hpix, i_vpix;
    logic v_init, h_init, h_step, h_char;

    logic        rdena, rdena0;
    logic [11:0] addr, addr0;
    logic [7:0]  cdata, cdata0, fdata, fdata0;
    logic [10:0] faddr, faddr0;
    logic        o_pix, o_pix0;
    logic [7:0]  o_attr, o_attr0;
    logic        o_hsync, o_vsync, o_hpix, o_vpix;
    logic        o_hsync0, o_vsync0, o_hpix0, o_vpix0;

    logic [7:0] mem      [0:4095];
    logic [7:0] font_mem [0:2047];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    text_fetch_gen dut (
        .clk(clk), .rst(rst), .pix_stb(pix_stb),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_hpix(i_hpix), .i_vpix(i_vpix),
        .v_init(v_init), .h_init(h_init), .h_step(h_step), .h_char(h_char),
        .char_r_rdena(rdena), .char_r_addr(addr), .char_r_data(cdata),
        .font_r_addr(faddr), .font_r_data(fdata),
        .o_pix(o_pix), .o_attr(o_attr),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_hpix(o_hpix), .o_vpix(o_vpix)
    );

    text_fetch_gen #(.ATTR_EN(0)) dut0 (
        .clk(clk), .rst(rst), .pix_stb(pix_stb),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_hpix(i_hpix), .i_vpix(i_vpix),
        .v_init(v_init), .h_init(h_init), .h_step(h_step), .h_char(h_char),
        .char_r_rdena(rdena0), .char_r_addr(addr0), .char_r_data(cdata0),
        .font_r_addr(faddr0), .font_r_data(fdata0),
        .o_pix(o_pix0), .o_attr(o_attr0),
        .o_hsync(o_hsync0), .o_vsync(o_vsync0), .o_hpix(o_hpix0), .o_vpix(o_vpix0)
    );

    always @(posedge clk) begin
        if (rdena)  cdata  <= mem[addr];
        if (rdena0) cdata0 <= mem[addr0];
        fdata  <= font_mem[faddr];
        fdata0 <= font_mem[faddr0];
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        v_init = 0; h_init = 0; h_step = 0; h_char = 0;
    endtask

    // One pix_stb tick followed by a 3-clk gap.
    task automatic gtick();
        pix_stb = 1;
        clk1();
        clear_strobes();
        pix_stb = 0;
        repeat (3) clk1();
        pix_stb = 1;
    endtask

    task automatic test_reset();
        int strobes;
        rst = 1;
        repeat (3) clk1();
        checks++; if (rdena !== 1'b0) begin failures++; $display("FAIL reset_rdena got=%b exp=0", rdena); end
        checks++; if (o_pix !== 1'b0) begin failures++; $display("FAIL reset_pix got=%b exp=0", o_pix); end
        checks++; if (o_attr !== 8'h07) begin failures++; $display("FAIL reset_attr got=%h exp=07", o_attr); end
        checks++; if ({o_hsync, o_vsync, o_hpix, o_vpix} !== 4'b0) begin
            failures++; $display("FAIL reset_timing got=%b exp=0000", {o_hsync, o_vsync, o_hpix, o_vpix}); end
        rst = 0;
        clk1();
        v_init = 1; clk1(); clear_strobes();
        h_init = 1; clk1(); clear_strobes();
        checks++; if (rdena !== 1'b1) begin failures++; $display("FAIL prereset_t0 got=%b exp=1", rdena); end
        #2 rst = 1;
        #1;
        checks++; if (rdena !== 1'b0) begin failures++; $display("FAIL midfetch_rdena got=%b exp=0", rdena); end
        checks++; if (o_attr !== 8'h07) begin failures++; $display("FAIL midfetch_attr got=%h exp=07", o_attr); end
        clk1();
        rst = 0;
        strobes = 0;
        for (int i = 0; i < 24; i++) begin
            h_char = (i % 4 == 0);
            clk1();
            clear_strobes();
            if (rdena || rdena0) strobes++;
        end
        checks++; if (strobes !== 0) begin failures++; $display("FAIL no_strobe_before_hinit got=%0d exp=0", strobes); end
    endtask

    task automatic test_fetch();
        v_init = 1; clk1(); clear_strobes();
        h_init = 1; clk1(); clear_strobes();
        checks++; if ({rdena, addr} !== {1'b1, 12'h000}) begin
            failures++; $display("FAIL t0_char got=%b/%h exp=1/000", rdena, addr); end
        checks++; if (rdena0 !== 1'b1) begin failures++; $display("FAIL t0_rdena_noattr got=%b exp=1", rdena0); end
        clk1();
        checks++; if ({rdena, addr} !== {1'b1, 12'h9C0}) begin
            failures++; $display("FAIL t1_attr got=%b/%h exp=1/9c0", rdena, addr); end
        checks++; if (rdena0 !== 1'b0) begin failures++; $display("FAIL t1_rdena_noattr got=%b exp=0", rdena0); end
        clk1();
        checks++; if (faddr !== 11'h208) begin failures++; $display("FAIL font_addr got=%h exp=208", faddr); end
        checks++; if (rdena !== 1'b0) begin failures++; $display("FAIL t2_rdena got=%b exp=0", rdena); end
    endtask

    task automatic test_pixels();
        logic [7:0] pat;
        pat = 8'hA5;
        clk1(); clk1();
        h_char = 1; clk1(); clear_strobes();
        checks++; if (o_attr !== 8'h1E) begin failures++; $display("FAIL cell_attr got=%h exp=1e", o_attr); end
        checks++; if (o_attr0 !== 8'h07) begin failures++; $display("FAIL cell_attr_noattr got=%h exp=07", o_attr0); end
        checks++; if ({rdena, addr} !== {1'b1, 12'h001}) begin
            failures++; $display("FAIL next_cell_addr got=%b/%h exp=1/001", rdena, addr); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) clk1();
            checks++; if (o_pix !== pat[7-i]) begin
                failures++; $display("FAIL pix_seq[%0d] got=%b exp=%b", i, o_pix, pat[7-i]); end
        end
    endtask

    task automatic test_timing();
        i_hsync = 1; clk1(); i_hsync = 0;
        checks++; if (o_hsync !== 1'b1) begin failures++; $display("FAIL hsync_delay got=%b exp=1", o_hsync); end
        pix_stb = 0; clk1();
        checks++; if (o_hsync !== 1'b1) begin failures++; $display("FAIL hsync_hold got=%b exp=1", o_hsync); end
        pix_stb = 1; clk1();
        checks++; if (o_hsync !== 1'b0) begin failures++; $display("FAIL hsync_clear got=%b exp=0", o_hsync); end
        v_init = 1; clk1(); clear_strobes();
        h_init = 1; clk1(); clear_strobes();
        repeat (6) clk1();
        h_char = 1; i_hpix = 0; clk1(); clear_strobes();
        checks++; if ({o_pix, o_hpix} !== 2'b00) begin
            failures++; $display("FAIL pix_gate got=%b/%b exp=0/0", o_pix, o_hpix); end
        i_hpix = 1;
    endtask

    task automatic test_rows();
        v_init = 1; clk1(); clear_strobes();
        h_step = 1; clk1(); clear_strobes();
        h_init = 1; clk1(); clear_strobes();
        checks++; if (addr !== 12'h000) begin failures++; $display("FAIL line1_char got=%h exp=000", addr); end
        clk1(); clk1();
        checks++; if (faddr !== 11'h209) begin failures++; $display("FAIL line1_font got=%h exp=209", faddr); end
        h_step = 1; repeat (7) clk1(); clear_strobes();
        h_init = 1; clk1(); clear_strobes();
        checks++; if (addr !== 12'h03C) begin failures++; $display("FAIL row1_char got=%h exp=03c", addr); end
        clk1();
        checks++; if (addr !== 12'h9E8) begin failures++; $display("FAIL row1_attr got=%h exp=9e8", addr); end
        clk1();
        checks++; if (faddr !== 11'h218) begin failures++; $display("FAIL row1_font got=%h exp=218", faddr); end
    endtask

    task automatic test_addr_wrap();
        v_init = 1; clk1(); clear_strobes();
        h_step = 1; repeat (544) clk1(); clear_strobes();
        h_init = 1; clk1(); clear_strobes();
        checks++; if (addr !== 12'hFF0) begin failures++; $display("FAIL row68_char got=%h exp=ff0", addr); end
        clk1();
        checks++; if (addr !== 12'h460) begin failures++; $display("FAIL row68_attr got=%h exp=460", addr); end
        clk1(); clk1();
        h_step = 1; repeat (8) clk1(); clear_strobes();
        h_init = 1; clk1(); clear_strobes();
        checks++; if (addr !== 12'h02C) begin failures++; $display("FAIL wrap_char got=%h exp=02c", addr); end
        clk1();
        checks++; if (addr !== 12'h488) begin failures++; $display("FAIL wrap_attr got=%h exp=488", addr); end
        clk1(); clk1();
        h_step = 1; clk1(); clear_strobes();
        v_init = 1; h_step = 1; clk1(); clear_strobes();
        h_init = 1; clk1(); clear_strobes();
        checks++; if (addr !== 12'h000) begin failures++; $display("FAIL vinit_prio_char got=%h exp=000", addr); end
        clk1();
        checks++; if (addr !== 12'h9C0) begin failures++; $display("FAIL vinit_prio_attr got=%h exp=9c0", addr); end
        clk1();
        checks++; if (faddr !== 11'h208) begin failures++; $display("FAIL vinit_prio_line got=%h exp=208", faddr); end
    endtask

    task automatic test_gaps();
        logic [7:0] pat;
        pat = 8'hA5;
        v_init = 1; gtick();
        h_init = 1; gtick();
        repeat (6) gtick();
        h_char = 1; gtick();
        checks++; if (o_attr0 !== 8'h07) begin failures++; $display("FAIL gap_attr_noattr got=%h exp=07", o_attr0); end
        checks++; if (o_attr !== 8'h1E) begin failures++; $display("FAIL gap_attr got=%h exp=1e", o_attr); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) gtick();
            checks++; if ({o_pix, o_pix0} !== {pat[7-i], pat[7-i]}) begin
                failures++; $display("FAIL gap_pix[%0d] got=%b%b exp=%b%b", i, o_pix, o_pix0, pat[7-i], pat[7-i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
        mem[12'h000] = 8'h41;
        mem[12'h001] = 8'h42;
        mem[12'h03C] = 8'h43;
        mem[12'h9C0] = 8'h1E;
        font_mem[11'h208] = 8'hA5;
        font_mem[11'h209] = 8'h3C;
        rst = 1; pix_stb = 1;
        i_hsync = 0; i_vsync = 0; i_hpix = 1; i_vpix = 1;
        clear_strobes();

        test_reset();
        test_fetch();
        test_pixels();
        test_timing();
        test_rows();
        test_addr_wrap();
        test_gaps();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
